uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: arbiter state encoding, default end-of-line byte
// and a width helper for index ports.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam logic [7:0] EOL_DEFAULT = 8'h0A;

    // An index port is never narrower than one bit, even for a single source.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester found when
// scanning upward from ptr+1 and wrapping around to ptr.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Upper segment (above ptr) first, then the wrapped segment 0..ptr.
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (IW'(i) > ptr)) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (IW'(i) <= ptr)) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Locks the UART transmitter to one byte source per message; releases on an
// accepted end-of-line byte or after TIMEOUT consecutive empty cycles.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int          N       = 2,
    parameter logic [7:0]  EOL     = EOL_DEFAULT,
    parameter int          TIMEOUT = 16,
    localparam int         OW      = idx_width(N)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [8*N-1:0] src_data,
    input  logic [N-1:0]   src_empty,
    output logic [N-1:0]   src_get,
    output logic [7:0]     out,
    output logic           empty,
    input  logic           get,
    output logic [OW-1:0]  owner,
    output logic           locked
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  src_req;
    logic          pick_valid;
    logic [OW-1:0] pick_idx;
    logic          own_empty;
    logic [7:0]    own_data;
    logic          accept;
    logic          eol_pop;
    logic          timeout;

    // Idle counter holds at TIMEOUT instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CW'(TIMEOUT)) ? v : v + CW'(1);
    endfunction

    assign src_req = ~src_empty;

    rr_pick #(
        .N  (N),
        .IW (OW)
    ) u_rr_pick (
        .req   (src_req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        own_empty = 1'b1;
        own_data  = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (owner_q == OW'(i)) begin
                own_empty = src_empty[i];
                own_data  = src_data[8*i +: 8];
            end
        end
    end

    assign accept  = get && !own_empty;
    assign eol_pop = accept && (own_data == EOL);
    assign timeout = (cnt_q == CW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        out     = 8'h00;
        empty   = 1'b1;
        locked  = 1'b0;
        src_get = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_LOCK;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_LOCK: begin
                out    = own_data;
                empty  = own_empty;
                locked = 1'b1;
                for (int i = 0; i < N; i++) begin
                    src_get[i] = accept && (owner_q == OW'(i));
                end
                // EOL pop and timeout in the same cycle collapse to one release.
                if (eol_pop || timeout) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q;
                    owner_d = '0;
                    cnt_d   = '0;
                end else if (own_empty) begin
                    cnt_d = sat_inc(cnt_q);
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= OW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a message-level
// reference model holding each source as a byte queue.
module tb_uart_tx_arbiter;

    localparam int         N    = 2;
    localparam int         TO   = 16;
    localparam logic [7:0] EOLB = 8'h0A;

    logic           clock = 1'b0;
    logic           reset;
    logic [8*N-1:0] src_data;
    logic [N-1:0]   src_empty;
    logic [N-1:0]   src_get;
    logic [7:0]     out;
    logic           empty;
    logic           get;
    logic [0:0]     owner;
    logic           locked;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .N       (N),
        .EOL     (EOLB),
        .TIMEOUT (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .src_data  (src_data),
        .src_empty (src_empty),
        .src_get   (src_get),
        .out       (out),
        .empty     (empty),
        .get       (get),
        .owner     (owner),
        .locked    (locked)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Environment: pending bytes per source.
    logic [7:0] srcq [N][$];

    // Reference model state.
    bit m_lock;
    int m_owner;
    int m_ptr;
    int m_cnt;

    int         cyc;
    bit         prev_locked;
    bit         obs_locked;
    int         obs_owner;
    int         grant_log[$];
    logic [7:0] deliv[$];

    task automatic model_reset();
        m_lock  = 1'b0;
        m_owner = 0;
        m_ptr   = N - 1;
        m_cnt   = 0;
    endtask

    task automatic step(input logic [N-1:0] stall, input bit g);
        logic [N-1:0] se;
        logic [7:0]   d [N];
        logic [N-1:0] esg;
        logic [7:0]   eout;
        bit           eempty;
        bit           acc;
        bit           rel;
        int           pick;
        int           c;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            se[i] = stall[i] || (srcq[i].size() == 0);
            if (se[i]) d[i] = 8'($urandom);
            else       d[i] = srcq[i][0];
            src_empty[i]       = se[i];
            src_data[8*i +: 8] = d[i];
        end
        get = g;
        #1;
        esg    = '0;
        eout   = 8'h00;
        eempty = 1'b1;
        if (m_lock) begin
            eout         = d[m_owner];
            eempty       = se[m_owner];
            esg[m_owner] = g && !se[m_owner];
        end
        chk("locked",  32'(locked),  32'(m_lock));
        chk("owner",   32'(owner),   32'(m_owner));
        chk("empty",   32'(empty),   32'(eempty));
        chk("out",     32'(out),     32'(eout));
        chk("src_get", 32'(src_get), 32'(esg));
        obs_locked = locked;
        obs_owner  = int'(owner);
        if (locked && !prev_locked) grant_log.push_back(int'(owner));
        prev_locked = locked;
        if (g && !empty) deliv.push_back(out);
        if (!m_lock) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (pick < 0 && !se[c]) pick = c;
            end
            if (pick >= 0) begin
                m_lock  = 1'b1;
                m_owner = pick;
                m_cnt   = 0;
            end
        end else begin
            acc = g && !se[m_owner];
            rel = (acc && d[m_owner] == EOLB) || (m_cnt == TO);
            if (rel) begin
                m_lock  = 1'b0;
                m_ptr   = m_owner;
                m_owner = 0;
                m_cnt   = 0;
            end else if (se[m_owner]) begin
                if (m_cnt < TO) m_cnt = m_cnt + 1;
            end else begin
                m_cnt = 0;
            end
        end
        @(posedge clock);
        for (int i = 0; i < N; i++) if (esg[i]) void'(srcq[i].pop_front());
        cyc++;
    endtask

    task automatic run(input int n, input logic [N-1:0] stall, input int mode);
        bit g;
        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       g = 1'b0;
                1:       g = 1'b1;
                2:       g = (cyc % 4 == 3);
                default: g = 1'($urandom_range(0, 1));
            endcase
            step(stall, g);
        end
    endtask

    // Async reset pulse with live source traffic; outputs must be idle at once.
    task automatic reset_pulse();
        #2;
        reset     = 1'b1;
        get       = 1'b1;
        src_empty = '0;
        #1;
        chk("rst_locked",  32'(locked),  32'd0);
        chk("rst_empty",   32'(empty),   32'd1);
        chk("rst_out",     32'(out),     32'd0);
        chk("rst_src_get", 32'(src_get), 32'd0);
        chk("rst_owner",   32'(owner),   32'd0);
        @(posedge clock);
        #1;
        chk("rst_hold_locked",  32'(locked),  32'd0);
        chk("rst_hold_src_get", 32'(src_get), 32'd0);
        @(negedge clock);
        src_empty   = '1;
        get         = 1'b0;
        reset       = 1'b0;
        prev_locked = 1'b0;
        model_reset();
    endtask

    task automatic push_msg(input int s, input logic [7:0] b0, input logic [7:0] b1);
        srcq[s].push_back(b0);
        srcq[s].push_back(b1);
    endtask

    initial begin
        logic [7:0]   hi [4];
        logic [N-1:0] st;
        int           len;
        logic [7:0]   b;

        hi          = '{8'h48, 8'h69, 8'h0D, 8'h0A};
        reset       = 1'b0;
        get         = 1'b0;
        src_empty   = '1;
        src_data    = '0;
        cyc         = 0;
        prev_locked = 1'b0;
        model_reset();
        reset_pulse();

        // "Hi\r\n" from source 0, transmitter pops every 4 cycles.
        foreach (hi[i]) srcq[0].push_back(hi[i]);
        deliv.delete();
        run(24, 2'b00, 2);
        chk("hi_count", 32'(deliv.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < deliv.size()) chk("hi_byte", 32'(deliv[i]), 32'(hi[i]));
        end
        chk("hi_idle_after", 32'(obs_locked), 32'd0);

        // Both sources sending "A\n": grants alternate.
        reset_pulse();
        grant_log.delete();
        for (int r = 0; r < 2; r++) begin
            push_msg(0, 8'h41, EOLB);
            push_msg(1, 8'h41, EOLB);
        end
        run(20, 2'b00, 1);
        chk("rr_grants", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) chk("rr_order", 32'(grant_log[i]), 32'(i % 2));
        end

        // Source 1 sends one byte then goes empty with get held high.
        srcq[1].push_back(8'h41);
        run(1, 2'b00, 0);
        run(1, 2'b00, 1);
        chk("to_owner1", 32'(obs_owner), 32'd1);
        push_msg(0, 8'h55, EOLB);
        run(16, 2'b00, 1);
        chk("to_still_locked", 32'(obs_locked), 32'd1);
        run(1, 2'b00, 1);
        run(1, 2'b00, 1);
        chk("to_idle_gap", 32'(obs_locked), 32'd0);
        run(1, 2'b00, 1);
        chk("to_next_owner", 32'(obs_owner), 32'd0);
        chk("to_next_locked", 32'(obs_locked), 32'd1);
        run(4, 2'b00, 1);

        // EOL pop coincides with the timeout.
        reset_pulse();
        push_msg(0, 8'h41, EOLB);
        srcq[1].push_back(8'h42);
        push_msg(1, 8'h43, EOLB);
        run(1, 2'b00, 0);
        run(1, 2'b00, 1);
        run(16, 2'b01, 0);
        run(1, 2'b00, 1);
        chk("both_rel_locked", 32'(obs_locked), 32'd1);
        run(1, 2'b00, 0);
        chk("both_idle", 32'(obs_locked), 32'd0);
        run(1, 2'b00, 0);
        chk("both_next_owner", 32'(obs_owner), 32'd1);

        // Reset in the middle of source 1's message.
        run(1, 2'b00, 1);
        chk("mid_locked", 32'(obs_locked), 32'd1);
        push_msg(0, 8'h66, EOLB);
        reset_pulse();
        run(2, 2'b00, 1);
        chk("post_rst_owner", 32'(obs_owner), 32'd0);
        run(8, 2'b00, 1);

        // Random traffic.
        reset_pulse();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() < 3 && $urandom_range(0, 7) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) begin
                        b = 8'($urandom_range(0, 255));
                        if (b == EOLB) b = 8'h0B;
                        srcq[i].push_back(b);
                    end
                    srcq[i].push_back(EOLB);
                end
            end
            st = N'($urandom) & N'($urandom);
            run(1, st, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
